// File: rtl/lock_sequencer_if.sv
// Key-event input and display/status output bundle for the lock sequencer.
// The master side (keypad chain / bench) drives keys, the slave side (sequencer)
// drives the entry buffer and status flags.
interface lock_sequencer_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       prog_en;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [2:0] digit_cnt;
  logic [2:0] state;
  logic       unlocked;
  logic       locked_out;
  logic       fail;
  logic       prog_done;

  modport master (
    output key_valid, key_code, prog_en,
    input  digit0, digit1, digit2, digit3, digit_cnt, state,
           unlocked, locked_out, fail, prog_done
  );

  modport slave (
    input  key_valid, key_code, prog_en,
    output digit0, digit1, digit2, digit3, digit_cnt, state,
           unlocked, locked_out, fail, prog_done
  );
endinterface

// File: rtl/lock_sequencer.sv
// Keypad lock sequencer: owns the 4-digit entry buffer, compares entries
// against the stored code, and sequences unlock, relock, lockout and
// code programming. A ms timer provides the entry, open and lockout timeouts.
module lock_sequencer #(
  parameter int unsigned CLK_FREQ         = 50_000_000,
  parameter int unsigned UNLOCK_MS        = 5000,
  parameter int unsigned ENTRY_TIMEOUT_MS = 10000,
  parameter int unsigned LOCKOUT_MS       = 30000,
  parameter int unsigned MAX_FAIL         = 3,
  parameter logic [15:0] DEFAULT_CODE     = 16'h1234
) (
  input  logic          clk,
  input  logic          rst_n,
  lock_sequencer_if.slave bus
);

  localparam int unsigned MS_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int unsigned PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int unsigned MAX_A  = (UNLOCK_MS > ENTRY_TIMEOUT_MS) ? UNLOCK_MS : ENTRY_TIMEOUT_MS;
  localparam int unsigned MAX_MS = (MAX_A > LOCKOUT_MS) ? MAX_A : LOCKOUT_MS;
  localparam int unsigned MS_W   = $clog2(MAX_MS + 1);

  // Expiry is detected one tick early so the transition lands exactly
  // limit*MS_DIV cycles after the timer was cleared.
  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(MS_DIV - 1);
  localparam logic [MS_W-1:0]  UNLOCK_LAST  = MS_W'(UNLOCK_MS - 1);
  localparam logic [MS_W-1:0]  ENTRY_LAST   = MS_W'(ENTRY_TIMEOUT_MS - 1);
  localparam logic [MS_W-1:0]  LOCKOUT_LAST = MS_W'(LOCKOUT_MS - 1);
  localparam logic [2:0]       FAIL_LIMIT   = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4,
    S_PROG    = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        digit_reg  [0:3];
  logic [3:0]        digit_next [0:3];
  logic [2:0]        cnt_reg, cnt_next;
  logic [15:0]       code_reg, code_next;
  logic [2:0]        fail_cnt_reg, fail_cnt_next;
  logic              fail_reg, fail_next;
  logic              prog_done_reg, prog_done_next;
  logic [PRE_W-1:0]  pre_reg;
  logic [MS_W-1:0]   ms_reg;

  logic              key_digit, key_clear, key_enter;
  logic              timed, expire, match;
  logic              capture, zero_buf, key_restart, timer_clear;
  logic [MS_W-1:0]   limit_last;
  logic [15:0]       entry_word;

  assign key_digit  = bus.key_valid && (bus.key_code <= 4'hD);
  assign key_clear  = bus.key_valid && (bus.key_code == 4'hE);
  assign key_enter  = bus.key_valid && (bus.key_code == 4'hF);
  assign entry_word = {digit_reg[0], digit_reg[1], digit_reg[2], digit_reg[3]};
  assign match      = (cnt_reg == 3'd4) && (entry_word == code_reg);

  // Select the timeout that applies to the current state.
  always_comb begin
    timed      = 1'b1;
    limit_last = ENTRY_LAST;
    case (state_reg)
      S_ENTRY, S_PROG: limit_last = ENTRY_LAST;
      S_OPEN:          limit_last = UNLOCK_LAST;
      S_LOCKOUT:       limit_last = LOCKOUT_LAST;
      default:         timed      = 1'b0;
    endcase
  end

  assign expire = timed && (pre_reg == PRE_LAST) && (ms_reg == limit_last);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 3'd0;
      code_reg      <= DEFAULT_CODE;
      fail_cnt_reg  <= 3'd0;
      fail_reg      <= 1'b0;
      prog_done_reg <= 1'b0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      code_reg      <= code_next;
      fail_cnt_reg  <= fail_cnt_next;
      fail_reg      <= fail_next;
      prog_done_reg <= prog_done_next;
      for (int i = 0; i < 4; i++) digit_reg[i] <= digit_next[i];
    end
  end

  // Millisecond timer: prescaler ticks the ms counter; cleared on state change or key activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_reg <= '0;
      ms_reg  <= '0;
    end else if (timer_clear) begin
      pre_reg <= '0;
      ms_reg  <= '0;
    end else if (pre_reg == PRE_LAST) begin
      pre_reg <= '0;
      ms_reg  <= ms_reg + 1'b1;
    end else begin
      pre_reg <= pre_reg + 1'b1;
    end
  end

  // Next-state and datapath update: key handling, compare, programming.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    code_next      = code_reg;
    fail_cnt_next  = fail_cnt_reg;
    fail_next      = 1'b0;
    prog_done_next = 1'b0;
    capture        = 1'b0;
    zero_buf       = 1'b0;
    key_restart    = 1'b0;
    for (int i = 0; i < 4; i++) digit_next[i] = digit_reg[i];

    case (state_reg)
      S_IDLE: begin
        if (key_digit) begin
          capture    = 1'b1;
          state_next = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (bus.key_valid) begin
          key_restart = 1'b1;
          if (key_clear) begin
            zero_buf   = 1'b1;
            state_next = S_IDLE;
          end else if (key_enter) begin
            state_next = S_CHECK;
          end else begin
            capture = 1'b1;
          end
        end else if (expire) begin
          zero_buf   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_CHECK: begin
        zero_buf = 1'b1;
        if (match) begin
          fail_cnt_next = 3'd0;
          state_next    = S_OPEN;
        end else begin
          fail_next = 1'b1;
          if (fail_cnt_reg + 3'd1 == FAIL_LIMIT) begin
            fail_cnt_next = 3'd0;
            state_next    = S_LOCKOUT;
          end else begin
            fail_cnt_next = fail_cnt_reg + 3'd1;
            state_next    = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (bus.key_valid) begin
          key_restart = 1'b1;
          if (key_clear) begin
            state_next = S_IDLE;
          end else if (key_digit && bus.prog_en) begin
            capture    = 1'b1;
            state_next = S_PROG;
          end
        end else if (expire) begin
          state_next = S_IDLE;
        end
      end
      S_PROG: begin
        if (bus.key_valid) begin
          key_restart = 1'b1;
          if (key_enter) begin
            zero_buf   = 1'b1;
            state_next = S_IDLE;
            if (cnt_reg == 3'd4) begin
              code_next      = entry_word;
              prog_done_next = 1'b1;
            end else begin
              fail_next = 1'b1;
            end
          end else if (key_clear) begin
            zero_buf   = 1'b1;
            state_next = S_IDLE;
          end else begin
            capture = 1'b1;
          end
        end else if (expire) begin
          zero_buf   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (expire) state_next = S_IDLE;
      end
      default: begin
        zero_buf   = 1'b1;
        state_next = S_IDLE;
      end
    endcase

    // Digits fill left to right; a full buffer silently drops extra digits.
    if (capture && (cnt_reg < 3'd4)) begin
      digit_next[cnt_reg[1:0]] = bus.key_code;
      cnt_next                 = cnt_reg + 3'd1;
    end
    if (zero_buf) begin
      for (int i = 0; i < 4; i++) digit_next[i] = 4'd0;
      cnt_next = 3'd0;
    end

    timer_clear = (state_next != state_reg) || key_restart || !timed;
  end

  // Output decode: buffer, state and status flags; the stored code stays internal.
  always_comb begin
    bus.digit0     = digit_reg[0];
    bus.digit1     = digit_reg[1];
    bus.digit2     = digit_reg[2];
    bus.digit3     = digit_reg[3];
    bus.digit_cnt  = cnt_reg;
    bus.state      = state_reg;
    bus.unlocked   = (state_reg == S_OPEN);
    bus.locked_out = (state_reg == S_LOCKOUT);
    bus.fail       = fail_reg;
    bus.prog_done  = prog_done_reg;
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model of the lock.
module tb_lock_sequencer;
  localparam int CPM   = 10;   // cycles per ms at CLK_FREQ=10_000
  localparam int T_UNL = 5;
  localparam int T_ENT = 8;
  localparam int T_LCK = 20;
  localparam int MAXF  = 3;

  localparam int ST_IDLE = 0, ST_ENTRY = 1, ST_CHECK = 2, ST_OPEN = 3, ST_LOCKOUT = 4, ST_PROG = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  lock_sequencer_if bus();

  lock_sequencer #(
    .CLK_FREQ(10_000), .UNLOCK_MS(T_UNL), .ENTRY_TIMEOUT_MS(T_ENT),
    .LOCKOUT_MS(T_LCK), .MAX_FAIL(MAXF), .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  int          m_state;
  int          m_q[$];
  logic [15:0] m_code;
  int          m_fails;
  int          m_elapsed;
  bit          m_fail, m_pd;

  function automatic logic [3:0] m_digit(input int i);
    int v;
    if (i >= m_q.size()) return 4'd0;
    v = m_q[i];
    return v[3:0];
  endfunction

  function automatic logic [15:0] m_word();
    return {m_digit(0), m_digit(1), m_digit(2), m_digit(3)};
  endfunction

  function automatic void model_reset();
    m_state = ST_IDLE; m_q.delete(); m_code = 16'h1234;
    m_fails = 0; m_elapsed = 0; m_fail = 0; m_pd = 0;
  endfunction

  function automatic void model_step(input bit kv, input logic [3:0] kc, input bit pe);
    int prev, lim;
    bit expire, is_digit, restart;
    prev = m_state; m_fail = 0; m_pd = 0; restart = 0;
    is_digit = kv && (kc <= 4'hD);
    case (m_state)
      ST_ENTRY, ST_PROG: lim = T_ENT;
      ST_OPEN:           lim = T_UNL;
      ST_LOCKOUT:        lim = T_LCK;
      default:           lim = 0;
    endcase
    expire = (lim != 0) && (m_elapsed == lim * CPM - 1);
    case (m_state)
      ST_IDLE: if (is_digit) begin m_q.push_back(int'(kc)); m_state = ST_ENTRY; end
      ST_ENTRY: begin
        if (kv) begin
          restart = 1;
          if (kc == 4'hE) m_state = ST_IDLE;
          else if (kc == 4'hF) m_state = ST_CHECK;
          else if (m_q.size() < 4) m_q.push_back(int'(kc));
        end else if (expire) m_state = ST_IDLE;
      end
      ST_CHECK: begin
        if (m_q.size() == 4 && m_word() == m_code) begin
          m_state = ST_OPEN; m_fails = 0;
        end else begin
          m_fail = 1; m_fails++;
          if (m_fails == MAXF) begin m_state = ST_LOCKOUT; m_fails = 0; end
          else m_state = ST_IDLE;
        end
        m_q.delete();
      end
      ST_OPEN: begin
        if (kv) begin
          restart = 1;
          if (kc == 4'hE) m_state = ST_IDLE;
          else if (is_digit && pe) begin m_state = ST_PROG; m_q.push_back(int'(kc)); end
        end else if (expire) m_state = ST_IDLE;
      end
      ST_PROG: begin
        if (kv) begin
          restart = 1;
          if (kc == 4'hF) begin
            if (m_q.size() == 4) begin m_code = m_word(); m_pd = 1; end
            else m_fail = 1;
            m_state = ST_IDLE;
          end else if (kc == 4'hE) m_state = ST_IDLE;
          else if (m_q.size() < 4) m_q.push_back(int'(kc));
        end else if (expire) m_state = ST_IDLE;
      end
      ST_LOCKOUT: if (expire) m_state = ST_IDLE;
      default: m_state = ST_IDLE;
    endcase
    if (m_state == ST_IDLE) m_q.delete();
    if (m_state != prev || restart) m_elapsed = 0; else m_elapsed++;
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic tick(input bit kv, input logic [3:0] kc);
    @(negedge clk);
    bus.key_valid = kv;
    bus.key_code  = kc;
    @(posedge clk);
    model_step(kv, kc, bus.prog_en);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] kc);
    tick(1'b1, kc);
  endtask

  task automatic enter_code(input logic [15:0] c);
    press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]); press(4'hF);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_valid = 1'b0; bus.key_code = 4'h0; bus.prog_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (bus.state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", bus.state); else n_pass++;
    n_checks++; if ({bus.digit0, bus.digit1, bus.digit2, bus.digit3} !== 16'h0) $display("FAIL reset_digits: got %h expected 0000", {bus.digit0, bus.digit1, bus.digit2, bus.digit3}); else n_pass++;
    n_checks++; if ({bus.digit_cnt, bus.unlocked, bus.locked_out, bus.fail, bus.prog_done} !== 7'd0) $display("FAIL reset_flags: got %b expected 0000000", {bus.digit_cnt, bus.unlocked, bus.locked_out, bus.fail, bus.prog_done}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_correct_code();
    int n = 0;
    enter_code(16'h1234);
    n_checks++; if (bus.state !== 3'd2) $display("FAIL correct_check_state: got %0d expected 2", bus.state); else n_pass++;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 4'h0);
      if (bus.unlocked === 1'b1) n++; else break;
    end
    n_checks++; if (n !== T_UNL * CPM) $display("FAIL correct_open_cycles: got %0d expected %0d", n, T_UNL * CPM); else n_pass++;
    n_checks++; if (bus.state !== 3'd0 || bus.digit_cnt !== 3'd0 || bus.digit0 !== 4'd0) $display("FAIL correct_relock: got state %0d cnt %0d expected state 0 cnt 0", bus.state, bus.digit_cnt); else n_pass++;
  endtask

  task automatic test_wrong_lockout();
    int n = 0;
    for (int a = 0; a < 3; a++) begin
      enter_code(16'h1235);
      tick(1'b0, 4'h0);
      n_checks++; if (bus.fail !== 1'b1) $display("FAIL wrong_fail_pulse%0d: got %0d expected 1", a, bus.fail); else n_pass++;
      n_checks++; if (bus.locked_out !== (a == 2)) $display("FAIL wrong_locked_out%0d: got %0d expected %0d", a, bus.locked_out, a == 2); else n_pass++;
    end
    n = 1;
    for (int i = 0; i < 400; i++) begin
      tick(i < 12, 4'($urandom_range(0, 15)));
      if (bus.locked_out !== 1'b1) break;
      n++;
      if (i < 12) begin
        n_checks++; if (bus.digit_cnt !== 3'd0 || bus.state !== 3'd4) $display("FAIL lockout_key_ignored: got cnt %0d state %0d expected cnt 0 state 4", bus.digit_cnt, bus.state); else n_pass++;
      end
    end
    n_checks++; if (n !== T_LCK * CPM) $display("FAIL lockout_cycles: got %0d expected %0d", n, T_LCK * CPM); else n_pass++;
    n_checks++; if (bus.state !== 3'd0) $display("FAIL lockout_exit_state: got %0d expected 0", bus.state); else n_pass++;
  endtask

  task automatic test_short_overflow_clear();
    press(4'h1); press(4'h2); press(4'hF); tick(1'b0, 4'h0);
    n_checks++; if (bus.fail !== 1'b1) $display("FAIL short_fail: got %0d expected 1", bus.fail); else n_pass++;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h9);
    n_checks++; if (bus.digit_cnt !== 3'd4 || bus.digit3 !== 4'h4) $display("FAIL overflow_ignored: got cnt %0d d3 %0d expected cnt 4 d3 4", bus.digit_cnt, bus.digit3); else n_pass++;
    press(4'hE);
    n_checks++; if (bus.digit_cnt !== 3'd0 || bus.state !== 3'd0) $display("FAIL clear_idle: got cnt %0d state %0d expected 0 0", bus.digit_cnt, bus.state); else n_pass++;
  endtask

  task automatic test_entry_timeout();
    bit saw_fail = 0;
    enter_code(16'h1234); tick(1'b0, 4'h0); press(4'hE);  // clears the fail count
    press(4'h7);
    n_checks++; if (bus.state !== 3'd1 || bus.digit0 !== 4'h7) $display("FAIL timeout_start: got state %0d d0 %0d expected 1 7", bus.state, bus.digit0); else n_pass++;
    for (int i = 1; i < T_ENT * CPM; i++) begin
      tick(1'b0, 4'h0);
      if (bus.fail !== 1'b0 || bus.state !== 3'd1) saw_fail = 1;
    end
    n_checks++; if (saw_fail !== 1'b0) $display("FAIL timeout_early: got early exit or fail %0d expected 0", saw_fail); else n_pass++;
    tick(1'b0, 4'h0);
    n_checks++; if (bus.state !== 3'd0 || bus.digit0 !== 4'h0 || bus.fail !== 1'b0) $display("FAIL timeout_expire: got state %0d d0 %0d fail %0d expected 0 0 0", bus.state, bus.digit0, bus.fail); else n_pass++;
    for (int a = 0; a < 2; a++) begin
      enter_code(16'h4321); tick(1'b0, 4'h0);
      n_checks++; if (bus.fail !== 1'b1 || bus.state !== 3'd0) $display("FAIL timeout_no_lockout%0d: got fail %0d state %0d expected 1 0", a, bus.fail, bus.state); else n_pass++;
    end
  endtask

  task automatic test_programming();
    enter_code(16'h1234); tick(1'b0, 4'h0);
    bus.prog_en = 1'b1;
    press(4'h9);
    n_checks++; if (bus.state !== 3'd5 || bus.digit0 !== 4'h9) $display("FAIL prog_enter: got state %0d d0 %0d expected 5 9", bus.state, bus.digit0); else n_pass++;
    press(4'h8); press(4'h7); press(4'h6); press(4'hF);
    n_checks++; if (bus.prog_done !== 1'b1 || bus.state !== 3'd0) $display("FAIL prog_done: got pd %0d state %0d expected 1 0", bus.prog_done, bus.state); else n_pass++;
    bus.prog_en = 1'b0;
    tick(1'b0, 4'h0);
    n_checks++; if (bus.prog_done !== 1'b0) $display("FAIL prog_done_width: got %0d expected 0", bus.prog_done); else n_pass++;
    enter_code(16'h1234); tick(1'b0, 4'h0);
    n_checks++; if (bus.fail !== 1'b1 || bus.unlocked !== 1'b0) $display("FAIL prog_old_code: got fail %0d unl %0d expected 1 0", bus.fail, bus.unlocked); else n_pass++;
    enter_code(16'h9876); tick(1'b0, 4'h0);
    n_checks++; if (bus.unlocked !== 1'b1) $display("FAIL prog_new_code: got %0d expected 1", bus.unlocked); else n_pass++;
    press(4'hE);
  endtask

  task automatic test_reset_mid_prog();
    enter_code(16'h9876); tick(1'b0, 4'h0);
    bus.prog_en = 1'b1;
    press(4'h5); press(4'h5);
    n_checks++; if (bus.state !== 3'd5 || bus.digit_cnt !== 3'd2) $display("FAIL midprog_state: got state %0d cnt %0d expected 5 2", bus.state, bus.digit_cnt); else n_pass++;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (bus.state !== 3'd0 || bus.digit_cnt !== 3'd0 || bus.digit0 !== 4'd0 || bus.unlocked !== 1'b0) $display("FAIL async_reset: got state %0d cnt %0d d0 %0d expected 0 0 0", bus.state, bus.digit_cnt, bus.digit0); else n_pass++;
    bus.prog_en = 1'b0;
    #1 rst_n = 1'b1;
    enter_code(16'h1234); tick(1'b0, 4'h0);
    n_checks++; if (bus.unlocked !== 1'b1) $display("FAIL reset_default_code: got %0d expected 1", bus.unlocked); else n_pass++;
    press(4'hE);
  endtask

  task automatic test_random();
    int errs = 0;
    int steps = 0;
    for (int b = 0; b < 60; b++) begin
      bit          kvq[$];
      logic [3:0]  kcq[$];
      int          mode;
      logic [15:0] c;
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          c = m_code;
          for (int d = 0; d < 4; d++) begin
            kvq.push_back(1'b1); kcq.push_back(c[15:12]); c = c << 4;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin kvq.push_back(1'b0); kcq.push_back(4'h0); end
          end
          kvq.push_back(1'b1); kcq.push_back(4'hF);
        end
        1: for (int k = $urandom_range(1, 6); k > 0; k--) begin
             kvq.push_back(1'b1); kcq.push_back(4'($urandom_range(0, 15)));
             kvq.push_back(1'b0); kcq.push_back(4'h0);
           end
        2: for (int k = $urandom_range(1, 90); k > 0; k--) begin kvq.push_back(1'b0); kcq.push_back(4'h0); end
        default: begin
          bus.prog_en = 1'($urandom_range(0, 1));
          kvq.push_back(1'b1); kcq.push_back(4'($urandom_range(0, 13)));
        end
      endcase
      for (int s = 0; s < kvq.size(); s++) begin
        tick(kvq[s], kcq[s]);
        steps++;
        n_checks++;
        if (bus.state !== 3'(m_state) || bus.digit_cnt !== 3'(m_q.size()) ||
            {bus.digit0, bus.digit1, bus.digit2, bus.digit3} !== m_word() ||
            bus.unlocked !== (m_state == ST_OPEN) || bus.locked_out !== (m_state == ST_LOCKOUT) ||
            bus.fail !== m_fail || bus.prog_done !== m_pd) begin
          if (errs < 10) $display("FAIL random_step%0d: got st %0d cnt %0d dig %h f %0d pd %0d expected st %0d cnt %0d dig %h f %0d pd %0d",
                                  steps, bus.state, bus.digit_cnt, {bus.digit0, bus.digit1, bus.digit2, bus.digit3}, bus.fail, bus.prog_done,
                                  m_state, m_q.size(), m_word(), m_fail, m_pd);
          errs++;
        end else n_pass++;
      end
    end
    bus.prog_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_lockout();
    test_short_overflow_clear();
    test_entry_timeout();
    test_programming();
    test_reset_mid_prog();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
